// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode, plus redirect flush.
interface fetch_buffer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_instruction;
    logic [ADDRESS_BITS-1:0] in_PC;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_instruction;
    logic [ADDRESS_BITS-1:0] out_PC;

    modport master (
        output in_valid, in_instruction, in_PC, flush, out_ready,
        input  in_ready, out_valid, out_instruction, out_PC
    );

    modport slave (
        input  in_valid, in_instruction, in_PC, flush, out_ready,
        output in_ready, out_valid, out_instruction, out_PC
    );
endinterface

// File: rtl/fetch_buffer.sv
// Elastic circular FIFO of instruction/PC pairs between fetch and decode, cleared by flush.
// Optional FETCH_BUFFER_PERF_EN adds saturating bubble/flush event counters.
module fetch_buffer #(
    parameter int                    DEPTH        = 2,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 20,
    parameter logic [DATA_WIDTH-1:0] NOP_INST     = DATA_WIDTH'(32'h00000013)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_buffer_if.slave bus
`ifdef FETCH_BUFFER_PERF_EN
    ,
    output logic [31:0]   bubble_count,
    output logic [31:0]   flush_count
`endif
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_WIDTH + ADDRESS_BITS;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               push, pop, full, empty;

    // Status comes only from the registered count, so no input reaches an output.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    assign bus.in_ready        = ~full;
    assign bus.out_valid       = ~empty;
    assign bus.out_instruction = empty ? NOP_INST : mem_q[rd_ptr_q][ENTRY_W-1 -: DATA_WIDTH];
    assign bus.out_PC          = empty ? '0 : mem_q[rd_ptr_q][ADDRESS_BITS-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= {bus.in_instruction, bus.in_PC};
        end
    end

`ifdef FETCH_BUFFER_PERF_EN
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        if (empty && !bus.flush && bubble_count_q != 32'hFFFF_FFFF) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
        if (bus.flush && flush_count_q != 32'hFFFF_FFFF) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bubble_count = bubble_count_q;
    assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer at DEPTH=2 and DEPTH=4 against queue-based reference models.
module tb_fetch_buffer;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_buffer_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) ifa ();
    fetch_buffer_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) ifb ();

`ifdef FETCH_BUFFER_PERF_EN
    logic [31:0] bub_a_dut, fl_a_dut, bub_b_dut, fl_b_dut;
`endif

    fetch_buffer #(.DEPTH(2)) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (ifa)
`ifdef FETCH_BUFFER_PERF_EN
        ,
        .bubble_count(bub_a_dut),
        .flush_count (fl_a_dut)
`endif
    );

    fetch_buffer #(.DEPTH(4)) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (ifb)
`ifdef FETCH_BUFFER_PERF_EN
        ,
        .bubble_count(bub_b_dut),
        .flush_count (fl_b_dut)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: each queue entry is {instruction, PC}, head at index 0.
    logic [51:0] qa[$];
    logic [51:0] qb[$];
    int          bub_a_m = 0, bub_b_m = 0, fl_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [19:0] pc,
                         input logic fl, input logic rdy);
        ifa.in_valid = v;  ifa.in_instruction = instr; ifa.in_PC = pc;
        ifa.flush    = fl; ifa.out_ready      = rdy;
        ifb.in_valid = v;  ifb.in_instruction = instr; ifb.in_PC = pc;
        ifb.flush    = fl; ifb.out_ready      = rdy;
    endtask

    task automatic check_outputs();
        logic [51:0] ha, hb;
        ha = (qa.size() != 0) ? qa[0] : {NOP, 20'h0};
        hb = (qb.size() != 0) ? qb[0] : {NOP, 20'h0};
        check("a_out_valid", 64'(ifa.out_valid), 64'(qa.size() != 0));
        check("a_in_ready",  64'(ifa.in_ready),  64'(qa.size() != 2));
        check("a_out_instr", 64'(ifa.out_instruction), 64'(ha[51:20]));
        check("a_out_pc",    64'(ifa.out_PC),    64'(ha[19:0]));
        check("b_out_valid", 64'(ifb.out_valid), 64'(qb.size() != 0));
        check("b_in_ready",  64'(ifb.in_ready),  64'(qb.size() != 4));
        check("b_out_instr", 64'(ifb.out_instruction), 64'(hb[51:20]));
        check("b_out_pc",    64'(ifb.out_PC),    64'(hb[19:0]));
`ifdef FETCH_BUFFER_PERF_EN
        check("a_bubble", 64'(bub_a_dut), 64'(bub_a_m));
        check("a_flushc", 64'(fl_a_dut),  64'(fl_m));
        check("b_bubble", 64'(bub_b_dut), 64'(bub_b_m));
        check("b_flushc", 64'(fl_b_dut),  64'(fl_m));
`endif
    endtask

    // One clock cycle: drive, check current outputs, advance the models across the edge.
    task automatic step(input logic v, input logic [19:0] pc, input logic fl, input logic rdy,
                        output logic acc_a);
        logic [31:0] instr;
        logic        pa, pb, oa, ob;
        logic [51:0] e;
        instr = $urandom();
        drive(v, instr, pc, fl, rdy);
        #1;
        check_outputs();
        pa = v && (qa.size() < 2) && !fl;
        pb = v && (qb.size() < 4) && !fl;
        oa = (qa.size() != 0) && rdy && !fl;
        ob = (qb.size() != 0) && rdy && !fl;
        if (qa.size() == 0 && !fl) bub_a_m++;
        if (qb.size() == 0 && !fl) bub_b_m++;
        if (fl) fl_m++;
        acc_a = pa;
        @(posedge clock);
        #1;
        if (fl) begin
            $display("flush");
            qa.delete();
            qb.delete();
        end else begin
            if (oa) begin
                e = qa.pop_front();
                $display("A pop pc=%05h instr=%08h", e[19:0], e[51:20]);
            end
            if (ob) void'(qb.pop_front());
            if (pa) qa.push_back({instr, pc});
            if (pb) qb.push_back({instr, pc});
        end
    endtask

    task automatic reset_pulse();
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("rst_a_out_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_a_out_instr", 64'(ifa.out_instruction), 64'(NOP));
        check("rst_a_in_ready",  64'(ifa.in_ready), 64'd1);
        check("rst_a_out_pc",    64'(ifa.out_PC), 64'd0);
        check("rst_b_out_valid", 64'(ifb.out_valid), 64'd0);
        qa.delete();
        qb.delete();
        bub_a_m = 0;
        bub_b_m = 0;
        fl_m    = 0;
        $display("async reset pulse");
        #1 reset = 1'b1;
    endtask

    initial begin
        logic        acc;
        logic [19:0] pc;
        reset = 1'b0;
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Reset mid-stream, then first push after release must be first out.
        step(1'b1, 20'h00, 1'b0, 1'b0, acc);
        step(1'b1, 20'h04, 1'b0, 1'b0, acc);
        reset_pulse();
        step(1'b0, 20'h00, 1'b0, 1'b0, acc);
        step(1'b1, 20'h08, 1'b0, 1'b0, acc);
        step(1'b0, 20'h00, 1'b0, 1'b1, acc);
        step(1'b0, 20'h00, 1'b0, 1'b1, acc);

        // Streaming at one word per cycle.
        pc = 20'h0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pc, 1'b0, 1'b1, acc);
            pc = pc + 20'h4;
        end
        step(1'b0, 20'h0, 1'b0, 1'b1, acc);

        // Backpressure with fetch holding the refused word, then drain with a full-plus-pop cycle.
        pc = 20'h10;
        for (int i = 0; i < 4; i++) begin
            step(pc <= 20'h18, pc, 1'b0, 1'b0, acc);
            if (acc) pc = pc + 20'h4;
        end
        for (int i = 0; i < 5; i++) begin
            step(pc <= 20'h18, pc, 1'b0, 1'b1, acc);
            if (acc) pc = pc + 20'h4;
        end

        // Flush with a concurrent push: the pushed word is dropped.
        step(1'b1, 20'h20, 1'b0, 1'b0, acc);
        step(1'b1, 20'h24, 1'b1, 1'b0, acc);
        step(1'b1, 20'h40, 1'b0, 1'b0, acc);
        step(1'b0, 20'h00, 1'b0, 1'b1, acc);
        step(1'b0, 20'h00, 1'b0, 1'b1, acc);

        // Counter scenario: three idle cycles and one flush from a fresh reset.
        reset_pulse();
        step(1'b0, 20'h0, 1'b0, 1'b0, acc);
        step(1'b0, 20'h0, 1'b0, 1'b0, acc);
        step(1'b0, 20'h0, 1'b0, 1'b0, acc);
        step(1'b0, 20'h0, 1'b1, 1'b0, acc);
`ifdef FETCH_BUFFER_PERF_EN
        check("perf_bubble3", 64'(bub_a_dut), 64'd3);
        check("perf_flush1",  64'(fl_a_dut),  64'd1);
`endif

        // Random interleaving exercises pointer wrap in both depths.
        pc = 20'h100;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 7, pc, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 6, acc);
            if (acc) pc = pc + 20'h4;
        end
        step(1'b0, 20'h0, 1'b0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
